// File: rtl/intctl_pkg.sv
// Shared constants for the 8085 interrupt controller: source codes, restart vectors,
// SIM bit positions and FSM state encoding.
package intctl_pkg;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_INTR = 3'd1;
    localparam logic [2:0] SRC_R55  = 3'd2;
    localparam logic [2:0] SRC_R65  = 3'd3;
    localparam logic [2:0] SRC_R75  = 3'd4;
    localparam logic [2:0] SRC_TRAP = 3'd5;

    localparam logic [15:0] VEC_TRAP = 16'h0024;
    localparam logic [15:0] VEC_R75  = 16'h003C;
    localparam logic [15:0] VEC_R65  = 16'h0034;
    localparam logic [15:0] VEC_R55  = 16'h002C;
    localparam logic [15:0] VEC_INTR = 16'h0000;

    localparam int SIM_SOD = 7;
    localparam int SIM_SDE = 6;
    localparam int SIM_R75 = 4;
    localparam int SIM_MSE = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    function automatic logic [15:0] src_vec(input logic [2:0] src);
        case (src)
            SRC_TRAP: return VEC_TRAP;
            SRC_R75:  return VEC_R75;
            SRC_R65:  return VEC_R65;
            SRC_R55:  return VEC_R55;
            default:  return VEC_INTR;
        endcase
    endfunction

endpackage

// File: rtl/syncreg.sv
// Reset-cleared multi-stage flip-flop synchroniser for a bus of async pins.
// Latency STAGES cycles from pin to output; no flow control.
module syncreg #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/intctl85.sv
// 8085 interrupt controller: pin sync, TRAP/7.5 latches, IE, SIM/RIM, fixed-priority grant.
// Grant outputs appear one cycle after chk and are held until inta_done retires them.
module intctl85
    import intctl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  intpin,
    input  logic        sid,
    input  logic        chk,
    input  logic        ie_set,
    input  logic        ie_clr,
    input  logic        sim_wr,
    input  logic        rim_rd,
    input  logic [7:0]  acc,
    input  logic        inta_done,
    output logic        int_req,
    output logic [2:0]  int_src,
    output logic [15:0] int_vec,
    output logic        inta_cyc,
    output logic        wake,
    output logic [7:0]  rim_data,
    output logic        sod
);

    logic [5:0] sync;
    logic [4:0] pins;
    logic       sid_s;
    logic       trap_prev, r75_prev;
    logic       trap_pend, r75;
    logic       ie, ie_dly, ie_save, trap_flag;
    logic [2:0] mask;
    logic [0:0] state;
    logic [4:0] en;
    logic [2:0] gsrc;
    logic       grant, done;

    syncreg #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .din   ({sid, intpin}),
        .dout  (sync)
    );

    assign pins  = sync[4:0];
    assign sid_s = sync[5];

    assign en = {trap_pend,
                 r75     & ie & ~mask[2],
                 pins[2] & ie & ~mask[1],
                 pins[1] & ie & ~mask[0],
                 pins[0] & ie};
    assign wake = |en;

    always_comb begin
        gsrc = SRC_NONE;
        if      (en[4]) gsrc = SRC_TRAP;
        else if (en[3]) gsrc = SRC_R75;
        else if (en[2]) gsrc = SRC_R65;
        else if (en[1]) gsrc = SRC_R55;
        else if (en[0]) gsrc = SRC_INTR;
    end

    assign grant = (state == ST_IDLE) && chk && (|en);
    assign done  = (state == ST_ACK) && inta_done;

    // RIM reports the pre-TRAP IE until software has read it once after the TRAP.
    assign rim_data = {sid_s, r75, pins[2], pins[1], trap_flag ? ie_save : ie, mask};

    always_ff @(posedge clock) begin
        if (reset) begin
            trap_prev <= 1'b0;
            r75_prev  <= 1'b0;
            trap_pend <= 1'b0;
            r75       <= 1'b0;
            ie        <= 1'b0;
            ie_dly    <= 1'b0;
            ie_save   <= 1'b0;
            trap_flag <= 1'b0;
            mask      <= 3'b111;
            sod       <= 1'b0;
            state     <= ST_IDLE;
            int_req   <= 1'b0;
            int_src   <= SRC_NONE;
            int_vec   <= 16'h0000;
            inta_cyc  <= 1'b0;
        end else begin
            trap_prev <= pins[4];
            r75_prev  <= pins[3];

            if (pins[4] && !trap_prev)
                trap_pend <= 1'b1;
            else if (!pins[4] || (done && int_src == SRC_TRAP))
                trap_pend <= 1'b0;

            // A fresh edge beats a simultaneous SIM reset or acknowledge.
            if (pins[3] && !r75_prev)
                r75 <= 1'b1;
            else if ((done && int_src == SRC_R75) || (sim_wr && acc[SIM_R75]))
                r75 <= 1'b0;

            if (chk && ie_dly) begin
                ie     <= 1'b1;
                ie_dly <= 1'b0;
            end
            if (ie_set)
                ie_dly <= 1'b1;
            if (ie_clr || grant) begin
                ie     <= 1'b0;
                ie_dly <= 1'b0;
            end

            if (grant && gsrc == SRC_TRAP) begin
                trap_flag <= 1'b1;
                ie_save   <= ie;
            end else if (rim_rd) begin
                trap_flag <= 1'b0;
            end

            if (sim_wr && acc[SIM_MSE]) mask <= acc[2:0];
            if (sim_wr && acc[SIM_SDE]) sod  <= acc[SIM_SOD];

            case (state)
                ST_IDLE: if (grant) begin
                    state    <= ST_ACK;
                    int_req  <= 1'b1;
                    int_src  <= gsrc;
                    int_vec  <= src_vec(gsrc);
                    inta_cyc <= (gsrc == SRC_INTR);
                end
                default: if (done) begin
                    state    <= ST_IDLE;
                    int_req  <= 1'b0;
                    int_src  <= SRC_NONE;
                    int_vec  <= 16'h0000;
                    inta_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intctl85.sv
// Randomized scoreboard bench for intctl85 against an event-level model of the 8085 interrupt rules.
module tb_intctl85;

    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  intpin = 5'd0;
    logic        sid = 1'b0;
    logic        chk = 1'b0;
    logic        ie_set = 1'b0;
    logic        ie_clr = 1'b0;
    logic        sim_wr = 1'b0;
    logic        rim_rd = 1'b0;
    logic [7:0]  acc = 8'd0;
    logic        inta_done = 1'b0;
    logic        int_req;
    logic [2:0]  int_src;
    logic [15:0] int_vec;
    logic        inta_cyc;
    logic        wake;
    logic [7:0]  rim_data;
    logic        sod;

    always #5 clock = ~clock;

    intctl85 #(.SYNC_STAGES(S)) dut (
        .clock(clock), .reset(reset), .intpin(intpin), .sid(sid), .chk(chk),
        .ie_set(ie_set), .ie_clr(ie_clr), .sim_wr(sim_wr), .rim_rd(rim_rd), .acc(acc),
        .inta_done(inta_done), .int_req(int_req), .int_src(int_src), .int_vec(int_vec),
        .inta_cyc(inta_cyc), .wake(wake), .rim_data(rim_data), .sod(sod)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          src;
        logic [15:0] vec;
        logic        inta;
        int unsigned at;
    } exp_t;
    exp_t q[$];

    logic [15:0] vec_tab [6] = '{16'h0000, 16'h0000, 16'h002C, 16'h0034, 16'h003C, 16'h0024};

    // Model state, indexed by source number (1 INTR .. 5 TRAP) where it matters
    logic [4:0] m_pins;
    logic       m_sid, m_trap_pend, m_r75, m_ie, m_ie_dly, m_ie_save, m_trap_flag, m_sod;
    logic [2:0] m_mask;
    bit         m_in_ack;
    int         m_ack_src;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] m_en();
        logic [4:0] e;
        e[4] = m_trap_pend;
        e[3] = m_r75     & m_ie & ~m_mask[2];
        e[2] = m_pins[2] & m_ie & ~m_mask[1];
        e[1] = m_pins[1] & m_ie & ~m_mask[0];
        e[0] = m_pins[0] & m_ie;
        return e;
    endfunction

    function automatic int top_src(input logic [4:0] e);
        for (int i = 4; i >= 0; i--) if (e[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_pins = 5'd0; m_sid = 1'b0; m_trap_pend = 1'b0; m_r75 = 1'b0;
        m_ie = 1'b0; m_ie_dly = 1'b0; m_ie_save = 1'b0; m_trap_flag = 1'b0;
        m_sod = 1'b0; m_mask = 3'b111; m_in_ack = 0; m_ack_src = 0;
    endtask

    task automatic set_pins(input logic [4:0] p, input logic s);
        intpin = p;
        sid = s;
        repeat (S + 2) tick();
        if (p[4] && !m_pins[4]) m_trap_pend = 1'b1;
        if (!p[4])              m_trap_pend = 1'b0;
        if (p[3] && !m_pins[3]) m_r75 = 1'b1;
        m_pins = p;
        m_sid = s;
    endtask

    task automatic do_sim(input logic [7:0] a);
        sim_wr = 1'b1; acc = a;
        tick();
        sim_wr = 1'b0;
        if (a[3]) m_mask = a[2:0];
        if (a[6]) m_sod = a[7];
        if (a[4]) m_r75 = 1'b0;
    endtask

    task automatic do_ei();
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        m_ie_dly = 1'b1;
    endtask

    task automatic do_di();
        ie_clr = 1'b1; tick(); ie_clr = 1'b0;
        m_ie = 1'b0; m_ie_dly = 1'b0;
    endtask

    task automatic do_chk();
        logic [4:0] e;
        int s;
        exp_t x;
        e = m_en();
        chk = 1'b1; tick(); chk = 1'b0;
        if (!m_in_ack && e != 5'd0) begin
            s = top_src(e);
            x.src = s; x.vec = vec_tab[s]; x.inta = (s == 1); x.at = cyc;
            q.push_back(x);
            if (s == 5) begin m_trap_flag = 1'b1; m_ie_save = m_ie; end
            m_ie = 1'b0; m_ie_dly = 1'b0;
            m_in_ack = 1; m_ack_src = s;
        end else if (m_ie_dly) begin
            m_ie = 1'b1; m_ie_dly = 1'b0;
        end
    endtask

    task automatic do_done();
        inta_done = 1'b1; tick(); inta_done = 1'b0;
        if (m_in_ack) begin
            if (m_ack_src == 5) m_trap_pend = 1'b0;
            if (m_ack_src == 4) m_r75 = 1'b0;
            m_in_ack = 0;
        end
    endtask

    task automatic check_rim();
        logic [7:0] r;
        r = {m_sid, m_r75, m_pins[2], m_pins[1], m_trap_flag ? m_ie_save : m_ie, m_mask};
        expect_eq("rim_data", rim_data, r);
        expect_eq("wake", wake, |m_en());
        expect_eq("sod", sod, m_sod);
        rim_rd = 1'b1; tick(); rim_rd = 1'b0;
        m_trap_flag = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pops one expectation per new grant, then watches it stay stable and retire cleanly.
    initial begin
        exp_t cur;
        bit active = 0;
        bit rogue = 0;
        forever begin
            @(negedge clock);
            if (int_req === 1'b1 && !active) begin
                active = 1;
                if (q.size() == 0) begin
                    checks++; errors++; rogue = 1;
                    $display("FAIL unexpected_grant src=%0d required no grant", int_src);
                end else begin
                    rogue = 0;
                    cur = q.pop_front();
                    expect_eq("grant_src", int_src, cur.src);
                    expect_eq("grant_vec", int_vec, cur.vec);
                    expect_eq("grant_inta", inta_cyc, cur.inta);
                    expect_eq("grant_cycle", cyc, cur.at);
                end
            end else if (int_req === 1'b1) begin
                if (!rogue) begin
                    expect_eq("hold_src", int_src, cur.src);
                    expect_eq("hold_vec", int_vec, cur.vec);
                end
            end else if (active) begin
                active = 0;
                expect_eq("retire_src", int_src, 0);
                expect_eq("retire_vec", int_vec, 0);
                expect_eq("retire_inta", inta_cyc, 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycles=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        expect_eq("rst_int_req", int_req, 0);
        expect_eq("rst_int_src", int_src, 0);
        expect_eq("rst_int_vec", int_vec, 0);
        expect_eq("rst_inta_cyc", inta_cyc, 0);
        expect_eq("rst_sod", sod, 0);
        expect_eq("rst_rim", rim_data, 8'h07);

        // RST7.5 pulse latches without IE; nothing granted
        set_pins(5'h08, 1'b0);
        set_pins(5'h00, 1'b0);
        do_chk();
        expect_eq("t1_rim", rim_data, 8'h47);
        check_rim();

        // Unmask, enable, then 6.5 beats 5.5
        do_reset();
        do_sim(8'h08);
        do_ei();
        do_chk();
        set_pins(5'h06, 1'b0);
        do_chk();
        tick();
        do_done();
        check_rim();

        // TRAP with INTR; RIM shows pre-TRAP IE once; held TRAP does not re-grant
        set_pins(5'h00, 1'b0);
        do_ei();
        do_chk();
        set_pins(5'h11, 1'b0);
        do_chk();
        check_rim();
        check_rim();
        do_done();
        do_chk();

        // EI takes effect after the following instruction
        set_pins(5'h01, 1'b0);
        do_ei();
        do_chk();
        do_chk();
        tick();
        do_done();

        // RST7.5 edge lands in the same cycle as a SIM R7.5 reset: edge wins
        set_pins(5'h00, 1'b0);
        intpin = 5'h08;
        repeat (S) tick();
        sim_wr = 1'b1; acc = 8'h10;
        tick();
        sim_wr = 1'b0;
        m_pins = 5'h08; m_r75 = 1'b1;
        repeat (2) tick();
        check_rim();
        do_sim(8'hC0);
        check_rim();

        // Reset in the middle of an RST7.5 acknowledge
        do_ei();
        do_chk();
        do_chk();
        tick();
        do_reset();
        expect_eq("t6_int_req", int_req, 0);
        expect_eq("t6_int_src", int_src, 0);
        expect_eq("t6_rim", rim_data, 8'h07);
        set_pins(intpin, sid);
        do_chk();
        check_rim();

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1: set_pins(m_pins ^ 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                2:    do_sim(8'($urandom_range(0, 255)));
                3:    if (!m_in_ack) do_ei();
                4:    if (!m_in_ack && $urandom_range(0, 2) == 0) do_di();
                5, 6: do_chk();
                7:    if (m_in_ack) do_done(); else tick();
                8:    check_rim();
                default: if (m_in_ack) do_done(); else do_chk();
            endcase
        end
        if (m_in_ack) do_done();

        repeat (5) tick();
        expect_eq("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intctl85.md
Name: intctl85

Overview:
- 8085 interrupt controller: synchronises TRAP/RST7.5/RST6.5/RST5.5/INTR pins and holds pending state.
- Implements IE and the SIM/RIM mask/serial registers.
- At each instruction boundary, arbitrates by fixed priority and presents one granted request (vector plus source) to the core state machine.
- The state machine inserts the restart/INTA cycles and reports completion.

Parameters:
SYNC_STAGES, 2, flip-flop depth of pin synchroniser (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
intpin  in  5  async pins: 0 INTR, 1 RST5.5, 2 RST6.5, 3 RST7.5, 4 TRAP
sid  in  1  serial input pin (async, synchronised like intpin)
chk  in  1  instruction-boundary strobe, 1 cycle
ie_set  in  1  EI executed
ie_clr  in  1  DI executed
sim_wr  in  1  SIM strobe, data on acc
rim_rd  in  1  RIM strobe
acc  in  8  accumulator value for SIM
inta_done  in  1  core finished acknowledge sequence for current grant
int_req  out  1  grant valid
int_src  out  3  0 none, 1 INTR, 2 RST5.5, 3 RST6.5, 4 RST7.5, 5 TRAP
int_vec  out  16  restart address (0x0000 for INTR)
inta_cyc  out  1  1 = core must run INTA bus cycle (INTR) instead of internal restart
wake  out  1  any enabled source pending (HALT exit)
rim_data  out  8  RIM image
sod  out  1  serial output pin

Behaviour:
- Reset (synchronous): int_req=0, int_src=0, int_vec=0, inta_cyc=0, sod=0, IE=0, ie_dly=0, masks M7.5/M6.5/M5.5=1, r75 latch=0, trap_pend=0, trap_flag=0, FSM=IDLE, synchronisers cleared.
- Synchroniser: pin change at edge k is visible at sync output after edge k+SYNC_STAGES-1. Edge detectors register the prior synchronised value.
- TRAP: synchronised rising edge sets trap_pend. trap_pend clears when the synchronised level is low or on TRAP acknowledge. Non-maskable; ignores IE.
- RST7.5: synchronised rising edge sets r75. r75 clears on:
  - RST7.5 acknowledge, or
  - sim_wr with acc[4]=1, regardless of MSE.
  - If a set and a clear occur in the same cycle, set wins.
- RST6.5/5.5/INTR: level-sensitive on synchronised pins; no latch.
- Enabled: TRAP=trap_pend; 7.5=r75&IE&~M7.5; 6.5=pin&IE&~M6.5; 5.5=pin&IE&~M5.5; INTR=pin&IE.
- wake = OR of enabled terms (registered inputs, combinational OR).
- IE:
  - ie_set raises ie_dly; ie_dly transfers to IE at the next chk, so EI takes effect after the following instruction.
  - ie_clr clears IE and ie_dly immediately, and wins over a simultaneous ie_set.
  - Any grant clears IE and ie_dly.
- SIM (sim_wr):
  - acc[3]=1: M7.5/M6.5/M5.5 <= acc[2:0].
  - acc[6]=1: sod <= acc[7].
  - acc[4] as above.
- RIM: rim_data = {sid_sync, r75, pin6.5_sync, pin5.5_sync, IEx, M7.5, M6.5, M5.5}.
  - IEx = IE before the TRAP while trap_flag=1, else IE.
  - TRAP grant sets trap_flag and saves IE into ie_save; rim_rd clears trap_flag.
- FSM, two states:
  - IDLE: on chk with any enabled source, register the highest-priority source (TRAP > 7.5 > 6.5 > 5.5 > INTR). Set int_req=1, int_src and int_vec (TRAP 0x0024, 7.5 0x003C, 6.5 0x0034, 5.5 0x002C, INTR 0x0000 with inta_cyc=1). Go to ACK. Outputs are valid the cycle after chk.
  - ACK: outputs held stable; chk ignored; new pin events still latch. On inta_done: clear the granted latch (trap_pend or r75), drop int_req/int_src/int_vec/inta_cyc to 0 next cycle, return to IDLE.
  - chk in the same cycle as inta_done: ignored; earliest re-grant is the next chk.
  - Level sources that drop during ACK do not cancel the grant.
- reset mid-ACK: immediate return to IDLE with reset values; no latch retained.

Decomposition:
- Package intctl_pkg:
  - source codes SRC_NONE..SRC_TRAP (3-bit);
  - vector constants VEC_TRAP/VEC_R75/VEC_R65/VEC_R55;
  - RIM/SIM bit-position constants (SIM_SDE=6, SIM_R75=4, SIM_MSE=3);
  - FSM state encoding.
- One sub-module: syncreg, a SYNC_STAGES-deep reset-cleared flip-flop chain instantiated for the 6-bit {sid, intpin} bus.

Test Plan:
1. After reset, RST7.5 pulse high 4 cycles, no EI, chk -> no int_req; rim_data=0x47 (I7.5=1, IE=0, masks=7).
2. SIM acc=0x08, EI, chk, then RST6.5 and RST5.5 held high, chk -> grant int_src=3, int_vec=0x0034, int_req=1 one cycle after chk; inta_done -> int_req=0 next cycle, IE=0.
3. IE=1, masks 0, TRAP and INTR high, chk -> int_src=5, vec 0x0024, inta_cyc=0. After inta_done, TRAP held high, chk -> no re-grant (edge consumed). rim_rd before done shows IE bit=1 (pre-TRAP), next rim_rd shows 0.
4. EI then chk with INTR high -> no grant; second chk -> int_src=1, int_vec=0x0000, inta_cyc=1.
5. RST7.5 rising edge in the same cycle sim_wr acc=0x10 takes effect on r75 -> r75=1 (set wins); sim_wr acc=0xC0 -> sod=1.
6. Grant RST7.5, assert reset during ACK -> next cycle int_req=0, int_src=0, r75=0, masks=7, FSM IDLE; chk after reset -> no grant.
